// File: rtl/rv32i_pkg.sv
// Shared rv32i core types: hazard FSM states, forwarding selects and the stall/flush control bundle.
// Pure declarations: no latency or backpressure of its own.
package rv32i_pkg;

    typedef enum logic [1:0] {
        HZ_INIT     = 2'd0,
        HZ_RUN      = 2'd1,
        HZ_MEM_WAIT = 2'd2,
        HZ_ERR      = 2'd3
    } hz_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Field order mirrors the port order stallF..stallM, FlushD..FlushW.
    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } hz_ctrl_t;

    localparam hz_ctrl_t HZ_CTL_NONE = hz_ctrl_t'(7'b0000_000);
    localparam hz_ctrl_t HZ_CTL_INIT = hz_ctrl_t'(7'b1000_111);
    localparam hz_ctrl_t HZ_CTL_MEM  = hz_ctrl_t'(7'b1111_001);
    localparam hz_ctrl_t HZ_CTL_BR   = hz_ctrl_t'(7'b0000_110);
    localparam hz_ctrl_t HZ_CTL_LU   = hz_ctrl_t'(7'b1100_010);

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter with synchronous clear (clear beats increment).
// Latency: count visible one cycle after inc_i/clr_i; no backpressure, holds at all-ones.
module hazard_perf_cnt
    import rv32i_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the rv32i F/D/E/M/W pipeline: zero-latency stall/flush/forward controls from state + inputs.
// A data access held off by dmem_ready freezes F..M and bubbles W; a watchdog traps waits that never complete.
module hazard_ctrl
    import rv32i_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int INIT_CYC = 2,
    parameter int TIMEOUT  = 256,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic [REG_AW-1:0] rs1E,
    input  logic [REG_AW-1:0] rs2E,
    input  logic [REG_AW-1:0] rdE,
    input  logic              loadE,
    input  logic              pcsrcE,
    input  logic [REG_AW-1:0] rdM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              dmem_req_M,
    input  logic              dmem_ready,
    input  logic              cnt_clr,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              mem_timeout,
    output logic [1:0]        state
);

    localparam int INIT_W = $clog2(INIT_CYC + 1);
    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [INIT_W-1:0] INIT_LAST  = INIT_W'(INIT_CYC - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
    localparam bit WDOG_EN = (TIMEOUT != 0);

    hz_state_e         state_q, state_d;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic              memwait, load_use;
    hz_ctrl_t          run_ctl, ctl;
    logic              stall_inc, flush_inc;

    function automatic fwd_sel_e fwd_pick(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_m,
        input logic              we_w
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        if (we_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    assign memwait  = dmem_req_M & ~dmem_ready;
    assign load_use = loadE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

    // A frozen E keeps pcsrcE alive, so a branch seen during a wait is applied when the wait ends.
    always_comb begin
        run_ctl = HZ_CTL_NONE;
        if (memwait) begin
            run_ctl = HZ_CTL_MEM;
        end else if (pcsrcE) begin
            run_ctl = HZ_CTL_BR;
        end else if (load_use) begin
            run_ctl = HZ_CTL_LU;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        ctl        = HZ_CTL_NONE;
        case (state_q)
            HZ_INIT: begin
                ctl = HZ_CTL_INIT;
                if (init_cnt_q == INIT_LAST) begin
                    state_d = HZ_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + INIT_W'(1);
                end
            end
            HZ_RUN: begin
                ctl = run_ctl;
                if (memwait) begin
                    state_d    = HZ_MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            HZ_MEM_WAIT: begin
                ctl = run_ctl;
                if (!memwait) begin
                    state_d = HZ_RUN;
                end else if (WDOG_EN && (wait_cnt_q == WAIT_LIMIT)) begin
                    state_d   = HZ_ERR;
                    timeout_d = 1'b1;
                end else if (wait_cnt_q != WAIT_LIMIT) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            HZ_ERR: begin
                ctl = HZ_CTL_MEM;
            end
            default: begin
                ctl     = HZ_CTL_INIT;
                state_d = HZ_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HZ_INIT;
            init_cnt_q <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign stall_inc = ((state_q == HZ_RUN) || (state_q == HZ_MEM_WAIT)) && ctl.stall_f;
    assign flush_inc = (state_q == HZ_RUN) && ctl.flush_d;

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (stall_inc),
        .clr_i (cnt_clr),
        .cnt_o (stall_cnt)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (flush_inc),
        .clr_i (cnt_clr),
        .cnt_o (flush_cnt)
    );

    assign stallF      = ctl.stall_f;
    assign stallD      = ctl.stall_d;
    assign stallE      = ctl.stall_e;
    assign stallM      = ctl.stall_m;
    assign FlushD      = ctl.flush_d;
    assign FlushE      = ctl.flush_e;
    assign FlushW      = ctl.flush_w;
    assign forwardAE   = fwd_pick(rs1E, rdM, rdW, regwriteM, regwriteW);
    assign forwardBE   = fwd_pick(rs2E, rdM, rdW, regwriteM, regwriteW);
    assign mem_timeout = timeout_q;
    assign state       = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: per-cycle expected controls go through a scoreboard queue; counters checked directly.
module tb_hazard_ctrl;
    import rv32i_pkg::*;

    localparam int AW = 5;
    localparam int CW = 4;

    localparam logic [6:0] E_NONE = 7'b0000_000;
    localparam logic [6:0] E_INIT = 7'b1000_111;
    localparam logic [6:0] E_MEM  = 7'b1111_001;
    localparam logic [6:0] E_BR   = 7'b0000_110;
    localparam logic [6:0] E_LU   = 7'b1100_010;

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_MW   = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    typedef struct packed {
        logic          rst_n;
        logic          load;
        logic          pcsrc;
        logic          wem;
        logic          wew;
        logic          req;
        logic          rdy;
        logic          clr;
        logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    } stim_t;

    typedef struct packed {
        logic [6:0] ctl;
        logic [1:0] st;
        logic       to;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic          loadE, pcsrcE, regwriteM, regwriteW, dmem_req_M, dmem_ready, cnt_clr;
    logic          stallF, stallD, stallE, stallM, FlushD, FlushE, FlushW;
    logic [1:0]    forwardAE, forwardBE, state;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic          mem_timeout;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   win     = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(AW), .INIT_CYC(2), .TIMEOUT(4), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .loadE(loadE), .pcsrcE(pcsrcE), .rdM(rdM), .rdW(rdW),
        .regwriteM(regwriteM), .regwriteW(regwriteW),
        .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .mem_timeout(mem_timeout), .state(state)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t t;
        t       = '0;
        t.rst_n = 1'b1;
        return t;
    endfunction

    task automatic apply(input stim_t s, input logic [6:0] c, input logic [1:0] st,
                         input logic to = 1'b0, input logic [1:0] fa = 2'b00, input logic [1:0] fb = 2'b00);
        exp_t e;
        @(negedge clk);
        rst_n      = s.rst_n;
        loadE      = s.load;
        pcsrcE     = s.pcsrc;
        regwriteM  = s.wem;
        regwriteW  = s.wew;
        dmem_req_M = s.req;
        dmem_ready = s.rdy;
        cnt_clr    = s.clr;
        rs1D       = s.rs1d;
        rs2D       = s.rs2d;
        rs1E       = s.rs1e;
        rs2E       = s.rs2e;
        rdE        = s.rde;
        rdM        = s.rdm;
        rdW        = s.rdw;
        e.ctl = c;
        e.st  = st;
        e.to  = to;
        e.fa  = fa;
        e.fb  = fb;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                win++;
                check($sformatf("w%0d ctl", win),
                      32'({stallF, stallD, stallE, stallM, FlushD, FlushE, FlushW}), 32'(e.ctl));
                check($sformatf("w%0d state", win), 32'(state), 32'(e.st));
                check($sformatf("w%0d mem_timeout", win), 32'(mem_timeout), 32'(e.to));
                check($sformatf("w%0d forwardAE", win), 32'(forwardAE), 32'(e.fa));
                check($sformatf("w%0d forwardBE", win), 32'(forwardBE), 32'(e.fb));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL bench_timeout: got no finish, want finish before 50000");
        $fatal(1, "bench time limit");
    end

    initial begin
        stim_t s;
        rst_n = 1'b0;
        {loadE, pcsrcE, regwriteM, regwriteW, dmem_req_M, dmem_ready, cnt_clr} = '0;
        {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;

        // Held in reset, then two scrub cycles, then RUN.
        s = idle(); s.rst_n = 1'b0;
        apply(s, E_INIT, S_INIT);
        apply(s, E_INIT, S_INIT);
        #1;
        check("reset stall_cnt", 32'(stall_cnt), 32'd0);
        check("reset flush_cnt", 32'(flush_cnt), 32'd0);
        s = idle(); s.wem = 1'b1; s.rdm = 5'd3; s.rs1e = 5'd3;
        apply(s, E_INIT, S_INIT, 1'b0, 2'b10);
        s = idle();
        apply(s, E_INIT, S_INIT);
        apply(s, E_NONE, S_RUN);
        #1;
        check("init stall_cnt", 32'(stall_cnt), 32'd0);

        // Load-use: one bubble, then nothing when rdE is x0.
        s = idle(); s.load = 1'b1; s.rde = 5'd5; s.rs2d = 5'd5;
        apply(s, E_LU, S_RUN);
        s = idle();
        apply(s, E_NONE, S_RUN);
        #1;
        check("lu stall_cnt", 32'(stall_cnt), 32'd1);
        check("lu flush_cnt", 32'(flush_cnt), 32'd0);
        s = idle(); s.load = 1'b1;
        apply(s, E_NONE, S_RUN);
        s = idle();
        apply(s, E_NONE, S_RUN);
        #1;
        check("lu x0 stall_cnt", 32'(stall_cnt), 32'd1);

        // Branch wins over a simultaneous load-use.
        s = idle(); s.load = 1'b1; s.rde = 5'd5; s.rs1d = 5'd5; s.pcsrc = 1'b1;
        apply(s, E_BR, S_RUN);
        s = idle();
        apply(s, E_NONE, S_RUN);
        #1;
        check("br flush_cnt", 32'(flush_cnt), 32'd1);
        check("br stall_cnt", 32'(stall_cnt), 32'd1);

        // Forwarding priority M over W, x0 never forwarded.
        s = idle(); s.rdm = 5'd7; s.rdw = 5'd7; s.rs1e = 5'd7; s.rs2e = 5'd7; s.wem = 1'b1; s.wew = 1'b1;
        apply(s, E_NONE, S_RUN, 1'b0, 2'b10, 2'b10);
        s.wem = 1'b0;
        apply(s, E_NONE, S_RUN, 1'b0, 2'b01, 2'b01);
        s.rs1e = 5'd0;
        apply(s, E_NONE, S_RUN, 1'b0, 2'b00, 2'b01);

        // Memory wait with a branch pending: frozen for 3 cycles, branch applied on ready.
        s = idle(); s.req = 1'b1; s.pcsrc = 1'b1;
        apply(s, E_MEM, S_RUN);
        apply(s, E_MEM, S_MW);
        apply(s, E_MEM, S_MW);
        s.rdy = 1'b1;
        apply(s, E_BR, S_MW);
        s = idle();
        apply(s, E_NONE, S_RUN);
        #1;
        check("memwait stall_cnt", 32'(stall_cnt), 32'd4);

        // Watchdog: wait never completes, controller traps in ERR.
        s = idle(); s.req = 1'b1;
        apply(s, E_MEM, S_RUN);
        for (int i = 0; i < 5; i++) apply(s, E_MEM, S_MW);
        s.rdy = 1'b1;
        apply(s, E_MEM, S_ERR, 1'b1);
        s = idle(); s.pcsrc = 1'b1;
        apply(s, E_MEM, S_ERR, 1'b1);
        #1;
        check("err stall_cnt", 32'(stall_cnt), 32'd10);

        // Reset from ERR clears everything.
        s = idle(); s.rst_n = 1'b0;
        apply(s, E_INIT, S_INIT);
        #1;
        check("rst stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst flush_cnt", 32'(flush_cnt), 32'd0);
        s = idle();
        apply(s, E_INIT, S_INIT);
        apply(s, E_INIT, S_INIT);
        apply(s, E_NONE, S_RUN);

        // Reset in the middle of a memory wait.
        s = idle(); s.req = 1'b1;
        apply(s, E_MEM, S_RUN);
        apply(s, E_MEM, S_MW);
        s.rst_n = 1'b0;
        apply(s, E_INIT, S_INIT);
        s = idle();
        apply(s, E_INIT, S_INIT);
        apply(s, E_INIT, S_INIT);
        apply(s, E_NONE, S_RUN);
        #1;
        check("midwait stall_cnt", 32'(stall_cnt), 32'd0);

        // Saturation at all-ones, then clear beats a concurrent increment.
        s = idle(); s.load = 1'b1; s.rde = 5'd9; s.rs1d = 5'd9;
        for (int i = 0; i < 20; i++) apply(s, E_LU, S_RUN);
        s.clr = 1'b1;
        apply(s, E_LU, S_RUN);
        #1;
        check("sat stall_cnt", 32'(stall_cnt), 32'd15);
        s = idle();
        apply(s, E_NONE, S_RUN);
        #1;
        check("clr stall_cnt", 32'(stall_cnt), 32'd0);
        apply(s, E_NONE, S_RUN);
        #1;
        check("post clr stall_cnt", 32'(stall_cnt), 32'd0);

        @(negedge clk);
        #3;
        check("sb drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
